// File: rtl/project_echo_pkg.sv
// Shared types for the echo sample pacer.
// Sample width, pacer FSM states and a saturating increment helper.
package project_echo_pkg;

  localparam int ECHO_NBITS = 11;

  typedef logic [ECHO_NBITS-1:0] echo_sample_t;

  typedef enum logic [1:0] {
    PACER_IDLE,
    PACER_RUN,
    PACER_ISSUE
  } pacer_state_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/project_echo_SampleFifo.sv
// Sample FIFO for the pacer: no bypass, sync active-low reset.
// Exposes the head and the entry behind it for back-to-back issue.
module project_echo_SampleFifo #(
  parameter int NBITS = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [NBITS-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [NBITS-1:0]         head_o,
  output logic [NBITS-1:0]         head2_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NBITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
  assign head2_o = mem_q[rptr_q + AW'(1)];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/project_echo_sample_pacer.sv
// Paced sample transmitter feeding the echo unit's recv port.
// Define ECHO_PACER_ZERO_FILL_EN to issue zero samples on underrun.
module project_echo_sample_pacer
  import project_echo_pkg::*;
#(
  parameter int NBITS    = ECHO_NBITS,
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_en,
  input  logic [PERIOD_W-1:0]    cfg_period,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [NBITS-1:0]       in_msg,
  output logic                   send_val,
  input  logic                   send_rdy,
  output logic [NBITS-1:0]       send_msg,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            underrun_cnt,
  output logic [15:0]            late_cnt
);

  localparam int FW = $clog2(DEPTH) + 1;

`ifdef ECHO_PACER_ZERO_FILL_EN
  localparam bit ZERO_FILL = 1'b1;
`else
  localparam bit ZERO_FILL = 1'b0;
`endif

  pacer_state_t        state_q;
  logic [PERIOD_W-1:0] tick_cnt_q;
  logic                send_val_q;
  logic [NBITS-1:0]    send_msg_q;
  logic                zero_q;
  logic [15:0]         underrun_q;
  logic [15:0]         late_q;
  logic                rdy_q;

  logic                full;
  logic                empty;
  logic [NBITS-1:0]    head;
  logic [NBITS-1:0]    head2;
  logic                push;
  logic                pop;
  logic                hs;
  logic                tick;
  logic                service;
  logic                avail;
  logic                late_ev;
  logic [NBITS-1:0]    next_msg;
  logic [PERIOD_W-1:0] reload;

  assign in_rdy = rdy_q && !full;
  assign push   = in_val && in_rdy;
  assign hs     = (state_q == PACER_ISSUE) && send_rdy;
  assign pop    = hs && !zero_q;

  assign reload = (cfg_period == '0) ? '0
                : cfg_period - PERIOD_W'(1);
  assign tick   = (state_q != PACER_IDLE)
               && (tick_cnt_q == '0);

  // A tick on the handshake cycle looks past the entry being popped.
  assign avail    = pop ? (fifo_count >= FW'(2)) : !empty;
  assign next_msg = pop ? head2 : head;

  assign service = tick && cfg_en
                && ((state_q == PACER_RUN) || hs);
  assign late_ev = (state_q == PACER_ISSUE)
                && tick && !send_rdy;

  project_echo_SampleFifo #(
    .NBITS (NBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n_i     (reset),
    .push_i      (push),
    .push_data_i (in_msg),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (fifo_count),
    .head_o      (head),
    .head2_o     (head2)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= PACER_IDLE;
      tick_cnt_q <= '0;
      send_val_q <= 1'b0;
      send_msg_q <= '0;
      zero_q     <= 1'b0;
      underrun_q <= '0;
      late_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b1;

      if (state_q == PACER_IDLE) begin
        if (cfg_en) begin
          tick_cnt_q <= reload;
        end
      end else if (tick) begin
        tick_cnt_q <= reload;
      end else begin
        tick_cnt_q <= tick_cnt_q - PERIOD_W'(1);
      end

      if (late_ev) begin
        late_q <= sat_inc16(late_q);
      end
      if (service && !avail) begin
        underrun_q <= sat_inc16(underrun_q);
      end

      case (state_q)
        PACER_IDLE: begin
          if (cfg_en) begin
            state_q <= PACER_RUN;
          end
        end
        PACER_RUN: begin
          if (!cfg_en) begin
            state_q <= PACER_IDLE;
          end
        end
        PACER_ISSUE: begin
          if (hs) begin
            state_q    <= cfg_en ? PACER_RUN : PACER_IDLE;
            send_val_q <= 1'b0;
          end
        end
        default: state_q <= PACER_IDLE;
      endcase

      if (service) begin
        if (avail) begin
          state_q    <= PACER_ISSUE;
          send_val_q <= 1'b1;
          send_msg_q <= next_msg;
          zero_q     <= 1'b0;
        end else if (ZERO_FILL) begin
          state_q    <= PACER_ISSUE;
          send_val_q <= 1'b1;
          send_msg_q <= '0;
          zero_q     <= 1'b1;
        end
      end
    end
  end

  assign send_val     = send_val_q;
  assign send_msg     = send_msg_q;
  assign underrun_cnt = underrun_q;
  assign late_cnt     = late_q;

endmodule

// File: tb/tb_project_echo_sample_pacer.sv
// Bench for project_echo_sample_pacer: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_project_echo_sample_pacer;

  localparam int DEPTH = 8;

`ifdef ECHO_PACER_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_en;
  logic [15:0] cfg_period;
  logic        in_val;
  logic        in_rdy;
  logic [10:0] in_msg;
  logic        send_val;
  logic        send_rdy;
  logic [10:0] send_msg;
  logic [3:0]  fifo_count;
  logic [15:0] underrun_cnt;
  logic [15:0] late_cnt;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [10:0] m_q[$];
  bit          m_run, m_iss, m_zero, m_rdyok;
  int          m_cnt, m_ucnt, m_lcnt;
  logic [10:0] m_msg;

  always #5 clk = ~clk;

  project_echo_sample_pacer dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_en       (cfg_en),
    .cfg_period   (cfg_period),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_msg       (in_msg),
    .send_val     (send_val),
    .send_rdy     (send_rdy),
    .send_msg     (send_msg),
    .fifo_count   (fifo_count),
    .underrun_cnt (underrun_cnt),
    .late_cnt     (late_cnt)
  );

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_update();
    bit active, tick, hs, push, service;
    int reload;
    if (!reset) begin
      m_q.delete();
      m_run = 0; m_iss = 0; m_zero = 0; m_rdyok = 0;
      m_cnt = 0; m_ucnt = 0; m_lcnt = 0; m_msg = '0;
      return;
    end
    active = m_run || m_iss;
    tick   = active && (m_cnt == 0);
    hs     = m_iss && send_rdy;
    push   = in_val && m_rdyok && (m_q.size() < DEPTH);
    reload = (cfg_period == 0) ? 0 : int'(cfg_period) - 1;
    if (!active) begin
      if (cfg_en) m_cnt = reload;
    end else begin
      m_cnt = tick ? reload : m_cnt - 1;
    end
    if (m_iss && tick && !send_rdy) m_lcnt = sat16(m_lcnt);
    if (hs && !m_zero) void'(m_q.pop_front());
    service = tick && cfg_en && (m_run || hs);
    if (!active) m_run = cfg_en;
    else if (m_run) m_run = cfg_en;
    else if (hs) begin
      m_iss = 0;
      m_run = cfg_en;
    end
    if (service) begin
      if (m_q.size() > 0) begin
        m_msg = m_q[0]; m_zero = 0; m_iss = 1; m_run = 0;
      end else begin
        m_ucnt = sat16(m_ucnt);
        if (ZF) begin
          m_msg = '0; m_zero = 1; m_iss = 1; m_run = 0;
        end
      end
    end
    if (push) m_q.push_back(in_msg);
    m_rdyok = 1;
  endtask

  task automatic check_all();
    bit rdy;
    rdy = m_rdyok && (m_q.size() < DEPTH);
    check_eq("send_val", 32'(send_val), 32'(m_iss));
    check_eq("send_msg", 32'(send_msg), 32'(m_msg));
    check_eq("in_rdy", 32'(in_rdy), 32'(rdy));
    check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check_eq("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
    check_eq("late_cnt", 32'(late_cnt), 32'(m_lcnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; cfg_en = 1'b0; in_val = 1'b0; send_rdy = 1'b0;
    repeat (n) step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    logic [10:0] msgs[$];
    int          cyc[$];
    int          t, nv, n155;
    bit          acc, done;
    logic [10:0] t2v [3];
    t2v[0] = 11'h001; t2v[1] = 11'h7FF; t2v[2] = 11'h2AA;

    reset = 1'b0; cfg_en = 1'b0; cfg_period = 16'd1;
    in_val = 1'b0; in_msg = '0; send_rdy = 1'b0;

    // 1: reset mid-stream
    do_reset(2);
    cfg_period = 16'd1; cfg_en = 1'b1; send_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_val = 1'b1; in_msg = 11'(i + 3);
      step();
    end
    in_val = 1'b0;
    reset = 1'b0;
    repeat (3) step();
    check_eq("rst_send_val", 32'(send_val), 32'd0);
    check_eq("rst_send_msg", 32'(send_msg), 32'd0);
    check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_eq("rst_in_rdy", 32'(in_rdy), 32'd0);
    check_eq("rst_underrun", 32'(underrun_cnt), 32'd0);
    check_eq("rst_late", 32'(late_cnt), 32'd0);
    reset = 1'b1; cfg_en = 1'b0;
    step();
    check_eq("rel_in_rdy", 32'(in_rdy), 32'd1);

    // 2: paced stream, period 4
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      in_val = 1'b1; in_msg = t2v[i];
      step();
    end
    in_val = 1'b0;
    cfg_period = 16'd4; cfg_en = 1'b1; send_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (send_val) begin
        msgs.push_back(send_msg);
        cyc.push_back(i);
        if (msgs.size() == 3)
          check_eq("t2_underrun", 32'(underrun_cnt), 32'd0);
      end
      step();
    end
    check_eq("t2_nissue", 32'(msgs.size()), 32'd3);
    if (msgs.size() == 3) begin
      for (int i = 0; i < 3; i++)
        check_eq("t2_msg", 32'(msgs[i]), 32'(t2v[i]));
      check_eq("t2_gap1", 32'(cyc[1] - cyc[0]), 32'd4);
      check_eq("t2_gap2", 32'(cyc[2] - cyc[1]), 32'd4);
    end

    // 3: fill FIFO, ninth sample waits for a pop
    do_reset(1);
    in_val = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_msg = 11'(16'h100 + i);
      step();
    end
    check_eq("t3_count", 32'(fifo_count), 32'd8);
    check_eq("t3_in_rdy", 32'(in_rdy), 32'd0);
    cfg_period = 16'd1; cfg_en = 1'b1; send_rdy = 1'b1;
    in_msg = 11'h1FF;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (in_rdy) acc = 1;
      step();
    end
    in_val = 1'b0;
    check_eq("t3_accept", 32'(acc), 32'd1);
    cfg_en = 1'b0;
    repeat (30) step();

    // 4: send_rdy held low while 0x155 is issued
    do_reset(1);
    in_val = 1'b1; in_msg = 11'h155;
    step();
    in_val = 1'b0;
    cfg_period = 16'd2; cfg_en = 1'b1; send_rdy = 1'b0;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      done = send_val;
    end
    check_eq("t4_issue", 32'(done), 32'd1);
    check_eq("t4_msg0", 32'(send_msg), 32'h155);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t4_hold", 32'(send_msg), 32'h155);
    end
    check_eq("t4_late", 32'(late_cnt), 32'd2);
    send_rdy = 1'b1;
    n155 = 0;
    for (int i = 0; i < 6; i++) begin
      if (send_val && send_msg == 11'h155) n155++;
      step();
    end
    check_eq("t4_one_hs", 32'(n155), 32'd1);

    // 5: underruns on empty FIFO
    do_reset(1);
    cfg_period = 16'd3; send_rdy = 1'b1; cfg_en = 1'b1;
    nv = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (send_val) nv++;
    end
    check_eq("t5_underrun", 32'(underrun_cnt), 32'd4);
    check_eq("t5_issues", 32'(nv), ZF ? 32'd4 : 32'd0);

    // 6: period 0, disable during ISSUE
    do_reset(1);
    in_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_msg = 11'(16'h040 + i);
      step();
    end
    in_val = 1'b0;
    cfg_period = 16'd0; send_rdy = 1'b0; cfg_en = 1'b1;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      done = send_val;
    end
    check_eq("t6_issue", 32'(done), 32'd1);
    cfg_en = 1'b0;
    step(); step();
    check_eq("t6_pending", 32'(send_val), 32'd1);
    send_rdy = 1'b1;
    step();
    check_eq("t6_done", 32'(send_val), 32'd0);
    step(); step();
    check_eq("t6_idle", 32'(send_val), 32'd0);
    check_eq("t6_retain", 32'(fifo_count), 32'd3);

    // random traffic
    do_reset(1);
    cfg_en = 1'b1; cfg_period = 16'd2;
    for (int i = 0; i < 2000; i++) begin
      in_val   = 1'($urandom_range(0, 1));
      in_msg   = 11'($urandom);
      send_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) cfg_en = !cfg_en;
      if ($urandom_range(0, 59) == 0)
        cfg_period = 16'($urandom_range(0, 5));
      reset = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
